// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl: schedules brush and clear-sweep writes onto the canvas BRAM write port
module fb_write_ctrl #(
  parameter int WIDTH = 160,
  parameter int HEIGHT = 120,
  parameter logic [11:0] BG_COLOUR = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] cursor_pixel,
  input  logic [11:0] cursor_colour,
  input  logic        draw,
  input  logic        brush_big,
  input  logic        clear_req,
  output logic        we,
  output logic [14:0] waddr,
  output logic [11:0] wdata,
  output logic        busy,
  output logic        clear_done
);
  localparam int SIZE = WIDTH * HEIGHT;
  typedef enum logic [1:0] {IDLE, CLEAR, BRUSH} state_t;
  state_t state;
  logic [14:0] last_addr, addr_l, base, xs, ys, saddr;
  logic [11:0] last_colour, colour_l;
  logic last_valid, big_l, big, ok, start;
  logic [3:0] slot, k, dx, dy;
  // Slot k of the 3x3 brush: dx = k%3, dy = k/3 (offset by -1); a small brush is slot 4 only
  always_comb begin
    big = state == IDLE ? brush_big : big_l;
    base = state == IDLE ? cursor_pixel : addr_l;
    k = !big ? 4'd4 : state == IDLE ? 4'd0 : slot + 4'd1;
    dx = k % 4'd3;
    dy = k / 4'd3;
    xs = base % 15'(WIDTH);
    ys = base / 15'(WIDTH);
    ok = !(xs == 15'd0 && dx == 4'd0) && !(xs == 15'(WIDTH - 1) && dx == 4'd2) &&
         !(ys == 15'd0 && dy == 4'd0) && !(ys == 15'(HEIGHT - 1) && dy == 4'd2);
    saddr = base + 15'(dy) * 15'(WIDTH) + 15'(dx) - 15'(WIDTH + 1);
    start = draw && cursor_pixel < 15'(SIZE) &&
            (!last_valid || cursor_pixel != last_addr || cursor_colour != last_colour);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      we <= 1'b0;
      busy <= 1'b0;
      clear_done <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      last_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clear_done <= 1'b0;
          if (clear_req) begin
            state <= CLEAR;
            we <= 1'b1;
            busy <= 1'b1;
            waddr <= '0;
            wdata <= BG_COLOUR;
          end else if (start) begin
            state <= BRUSH;
            addr_l <= cursor_pixel;
            colour_l <= cursor_colour;
            big_l <= brush_big;
            slot <= 4'd0;
            busy <= 1'b1;
            we <= ok;
            if (ok) begin
              waddr <= saddr;
              wdata <= cursor_colour;
            end
          end
        end
        CLEAR: begin
          if (waddr == 15'(SIZE - 1)) begin
            state <= IDLE;
            we <= 1'b0;
            busy <= 1'b0;
            clear_done <= 1'b1;
            last_valid <= 1'b0;
          end else waddr <= waddr + 15'd1;
        end
        BRUSH: begin
          if (!big_l || slot == 4'd8) begin
            state <= IDLE;
            we <= 1'b0;
            busy <= 1'b0;
            last_addr <= addr_l;
            last_colour <= colour_l;
            last_valid <= 1'b1;
          end else begin
            slot <= slot + 4'd1;
            we <= ok;
            if (ok) begin
              waddr <= saddr;
              wdata <= colour_l;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_write_ctrl.sv
// tb_fb_write_ctrl: directed self-checking bench for fb_write_ctrl
module tb_fb_write_ctrl;
  logic clk = 0, reset, draw, brush_big, clear_req;
  logic [14:0] cursor_pixel, waddr;
  logic [11:0] cursor_colour, wdata;
  logic we, busy, clear_done;
  int checks = 0, errors = 0, nw, nb, nd, bad;
  int ea [9];
  fb_write_ctrl dut (
    .clk(clk), .reset(reset), .cursor_pixel(cursor_pixel), .cursor_colour(cursor_colour),
    .draw(draw), .brush_big(brush_big), .clear_req(clear_req), .we(we), .waddr(waddr),
    .wdata(wdata), .busy(busy), .clear_done(clear_done)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    nw = 0;
    nb = 0;
    nd = 0;
    repeat (n) begin
      step;
      nw += int'(we);
      nb += int'(busy);
      nd += int'(clear_done);
    end
  endtask
  task automatic brush_check(input logic [14:0] p, input logic [8:0] m, input logic [11:0] c);
    cursor_pixel = p;
    for (int i = 0; i < 9; i++) begin
      step;
      chk($sformatf("bbusy%0d@%0d", i, p), busy, 1);
      chk($sformatf("bwe%0d@%0d", i, p), we, m[i]);
      if (m[i]) begin
        chk($sformatf("baddr%0d@%0d", i, p), waddr, ea[i]);
        chk($sformatf("bdata%0d@%0d", i, p), wdata, c);
      end
    end
    step;
    chk("bend_busy", busy, 0);
    chk("bend_we", we, 0);
  endtask
  initial begin
    reset = 1; draw = 0; brush_big = 0; clear_req = 0; cursor_pixel = 0; cursor_colour = 0;
    step; step;
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_done", clear_done, 0);
    reset = 0; draw = 1; cursor_pixel = 100; cursor_colour = 12'hFFF;
    step;
    chk("px_we", we, 1);
    chk("px_addr", waddr, 100);
    chk("px_data", wdata, 12'hFFF);
    chk("px_busy", busy, 1);
    step;
    chk("px_end_we", we, 0);
    chk("px_end_busy", busy, 0);
    idle(20);
    chk("hold_writes", nw, 0);
    chk("hold_busy", nb, 0);
    cursor_colour = 12'hF00;
    step;
    chk("recol_we", we, 1);
    chk("recol_addr", waddr, 100);
    chk("recol_data", wdata, 12'hF00);
    step;
    chk("recol_end", we, 0);
    brush_big = 1;
    ea = '{160, 161, 162, 320, 321, 322, 480, 481, 482};
    brush_check(321, 9'b111111111, 12'hF00);
    idle(3);
    chk("big_hold", nw, 0);
    ea = '{0, 0, 0, 0, 0, 1, 0, 160, 161};
    brush_check(0, 9'b110110000, 12'hF00);
    ea = '{19038, 19039, 0, 19198, 19199, 0, 0, 0, 0};
    brush_check(19199, 9'b000011011, 12'hF00);
    clear_req = 1;
    step;
    clear_req = 0;
    bad = 0;
    for (int i = 0; i < 19200; i++) begin
      if (!(we === 1'b1 && waddr === 15'(i) && wdata === 12'h000 && busy === 1'b1 && clear_done === 1'b0)) bad++;
      step;
    end
    chk("clear_sweep_bad", bad, 0);
    chk("clear_done", clear_done, 1);
    chk("clear_done_busy", busy, 0);
    chk("clear_done_we", we, 0);
    brush_check(19199, 9'b000011011, 12'hF00);
    chk("after_clear_done", clear_done, 0);
    idle(5);
    chk("repaint_once", nw, 0);
    cursor_pixel = 19200;
    idle(5);
    chk("oor_we", nw, 0);
    chk("oor_busy", nb, 0);
    clear_req = 1; brush_big = 0; cursor_pixel = 100;
    step;
    clear_req = 0;
    chk("prio_addr", waddr, 0);
    chk("prio_data", wdata, 0);
    chk("prio_we", we, 1);
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      if (!(we === 1'b1 && waddr === 15'(i) && clear_done === 1'b0)) bad++;
      step;
    end
    chk("prio_sweep_bad", bad, 0);
    chk("mid_addr", waddr, 5000);
    reset = 1;
    step;
    chk("mrst_we", we, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_waddr", waddr, 0);
    chk("mrst_done", clear_done, 0);
    reset = 0;
    step;
    chk("post_rst_we", we, 1);
    chk("post_rst_addr", waddr, 100);
    chk("post_rst_data", wdata, 12'hF00);
    idle(30);
    chk("post_rst_writes", nw, 0);
    chk("post_rst_nodone", nd, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
